// File: rtl/pifo_pushout.sv
// rtl/pifo_pushout.sv - sorted-array PIFO with optional push-out on full and occupancy count
//
// Purpose:
//   Holds up to NUM_ELEMENTS (rank, payload) entries in a sorted register array.
//   Slot 0 is the head (lowest rank).
//   Equal ranks leave in arrival order.
//   With MODE_PUSHOUT=1 an enqueue on a full queue evicts the worst entry.
//   The worst entry is either the tail or the incoming entry, and it is
//   reported on the evict port.
//   With MODE_PUSHOUT=0 the queue back-pressures when full.
//
// Optional feature macro: PIFO_CLEAR_ALL_EN (adds i__clear_all)
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   i__clear_all                (PIFO_CLEAR_ALL_EN only) flush all entries
//   i__data_in_valid/_priority/i__data_in, o__data_in_ready    enqueue side
//   o__data_out_valid/_priority/o__data_out, i__data_out_ready dequeue side (registered head)
//   o__evict_valid/_priority/_data   one-cycle registered eviction report
//   o__count, o__full, o__empty      occupancy
module pifo_pushout #(
    parameter int NUM_ELEMENTS   = 16,
    parameter int PRIORITY_WIDTH = 8,
    parameter int DATA_WIDTH     = 16,
    parameter int MODE_PUSHOUT   = 1,
    localparam int CW            = $clog2(NUM_ELEMENTS + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
`ifdef PIFO_CLEAR_ALL_EN
    input  logic                      i__clear_all,
`endif
    input  logic                      i__data_in_valid,
    input  logic [PRIORITY_WIDTH-1:0] i__data_in_priority,
    input  logic [DATA_WIDTH-1:0]     i__data_in,
    output logic                      o__data_in_ready,
    output logic                      o__data_out_valid,
    output logic [PRIORITY_WIDTH-1:0] o__data_out_priority,
    output logic [DATA_WIDTH-1:0]     o__data_out,
    input  logic                      i__data_out_ready,
    output logic                      o__evict_valid,
    output logic [PRIORITY_WIDTH-1:0] o__evict_priority,
    output logic [DATA_WIDTH-1:0]     o__evict_data,
    output logic [CW-1:0]             o__count,
    output logic                      o__full,
    output logic                      o__empty
);

    logic [PRIORITY_WIDTH-1:0] slot_pri   [NUM_ELEMENTS];
    logic [DATA_WIDTH-1:0]     slot_data  [NUM_ELEMENTS];
    logic [NUM_ELEMENTS-1:0]   slot_valid;
    logic [CW-1:0]             count;

    logic [PRIORITY_WIDTH-1:0] base_pri   [NUM_ELEMENTS];
    logic [DATA_WIDTH-1:0]     base_data  [NUM_ELEMENTS];
    logic [PRIORITY_WIDTH-1:0] next_pri   [NUM_ELEMENTS];
    logic [DATA_WIDTH-1:0]     next_data  [NUM_ELEMENTS];
    logic [NUM_ELEMENTS-1:0]   next_valid;
    logic [CW-1:0]             base_cnt;
    logic [CW-1:0]             next_cnt;
    logic [CW-1:0]             pos;

    logic                      full;
    logic                      deq;
    logic                      accept;
    logic                      po_full;
    logic                      replace;
    logic                      reject;
    logic                      insert;
    logic                      evict_valid_n;
    logic [PRIORITY_WIDTH-1:0] evict_pri_n;
    logic [DATA_WIDTH-1:0]     evict_data_n;
    logic                      clear;

`ifdef PIFO_CLEAR_ALL_EN
    assign clear = i__clear_all;
`else
    assign clear = 1'b0;
`endif

    assign full                 = (count == CW'(NUM_ELEMENTS));
    assign o__full              = full;
    assign o__empty             = (count == '0);
    assign o__count             = count;
    assign o__data_out_valid    = ~o__empty;
    assign o__data_out_priority = slot_pri[0];
    assign o__data_out          = slot_data[0];
    assign o__data_in_ready     = (MODE_PUSHOUT != 0) ? 1'b1 : ~full;

    always_comb begin
        deq     = i__data_out_ready && (count != '0);
        accept  = i__data_in_valid && o__data_in_ready;
        // Only reachable in push-out mode; back-pressure mode never accepts on full.
        po_full = accept && full && !deq;
        replace = po_full && (i__data_in_priority < slot_pri[NUM_ELEMENTS-1]);
        reject  = po_full && !replace;
        insert  = accept && !reject;

        // Post-dequeue view of the array; vacated slots are kept at zero so
        // invalid slots always read as zero.
        base_cnt = count - CW'(deq);
        for (int i = 0; i < NUM_ELEMENTS; i++) begin
            if (deq) begin
                base_pri[i]  = (i < NUM_ELEMENTS - 1) ? slot_pri[(i < NUM_ELEMENTS - 1) ? i + 1 : i]  : '0;
                base_data[i] = (i < NUM_ELEMENTS - 1) ? slot_data[(i < NUM_ELEMENTS - 1) ? i + 1 : i] : '0;
            end else begin
                base_pri[i]  = slot_pri[i];
                base_data[i] = slot_data[i];
            end
        end

        // Insert after every valid entry whose rank is <= the incoming rank.
        pos = '0;
        for (int i = 0; i < NUM_ELEMENTS; i++) begin
            if ((CW'(i) < base_cnt) && (base_pri[i] <= i__data_in_priority))
                pos = pos + 1'b1;
        end

        // On replace the array is full.
        // The shift-right drops the old tail off the end.
        for (int i = 0; i < NUM_ELEMENTS; i++) begin
            if (!insert || (CW'(i) < pos)) begin
                next_pri[i]  = base_pri[i];
                next_data[i] = base_data[i];
            end else if (CW'(i) == pos) begin
                next_pri[i]  = i__data_in_priority;
                next_data[i] = i__data_in;
            end else begin
                next_pri[i]  = base_pri[(i == 0) ? 0 : i - 1];
                next_data[i] = base_data[(i == 0) ? 0 : i - 1];
            end
        end

        if (po_full)
            next_cnt = count;
        else
            next_cnt = base_cnt + CW'(insert);

        for (int i = 0; i < NUM_ELEMENTS; i++)
            next_valid[i] = (CW'(i) < next_cnt);

        evict_valid_n = po_full;
        evict_pri_n   = '0;
        evict_data_n  = '0;
        if (replace) begin
            evict_pri_n  = slot_pri[NUM_ELEMENTS-1];
            evict_data_n = slot_data[NUM_ELEMENTS-1];
        end else if (reject) begin
            evict_pri_n  = i__data_in_priority;
            evict_data_n = i__data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count             <= '0;
            slot_valid        <= '0;
            o__evict_valid    <= 1'b0;
            o__evict_priority <= '0;
            o__evict_data     <= '0;
            for (int i = 0; i < NUM_ELEMENTS; i++) begin
                slot_pri[i]  <= '0;
                slot_data[i] <= '0;
            end
        end else begin
            count             <= next_cnt;
            slot_valid        <= next_valid;
            o__evict_valid    <= evict_valid_n;
            o__evict_priority <= evict_pri_n;
            o__evict_data     <= evict_data_n;
            for (int i = 0; i < NUM_ELEMENTS; i++) begin
                slot_pri[i]  <= next_pri[i];
                slot_data[i] <= next_data[i];
            end
        end
    end

endmodule

// File: tb/tb_pifo_pushout.sv
// tb/tb_pifo_pushout.sv - directed self-checking bench for pifo_pushout (back-pressure and push-out instances)
module tb_pifo_pushout;

    localparam int N  = 16;
    localparam int PW = 8;
    localparam int DW = 16;
    localparam int CW = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          clear_all;
    logic          in_valid;
    logic [PW-1:0] in_pri;
    logic [DW-1:0] in_data;
    logic          out_ready;

    logic          bp_in_ready, bp_out_valid, bp_ev_valid, bp_full, bp_empty;
    logic [PW-1:0] bp_out_pri, bp_ev_pri;
    logic [DW-1:0] bp_out_data, bp_ev_data;
    logic [CW-1:0] bp_count;

    logic          po_in_ready, po_out_valid, po_ev_valid, po_full, po_empty;
    logic [PW-1:0] po_out_pri, po_ev_pri;
    logic [DW-1:0] po_out_data, po_ev_data;
    logic [CW-1:0] po_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pifo_pushout #(.NUM_ELEMENTS(N), .PRIORITY_WIDTH(PW), .DATA_WIDTH(DW), .MODE_PUSHOUT(0)) u_bp (
        .clk(clk), .reset(reset),
`ifdef PIFO_CLEAR_ALL_EN
        .i__clear_all(clear_all),
`endif
        .i__data_in_valid(in_valid), .i__data_in_priority(in_pri), .i__data_in(in_data),
        .o__data_in_ready(bp_in_ready), .o__data_out_valid(bp_out_valid),
        .o__data_out_priority(bp_out_pri), .o__data_out(bp_out_data),
        .i__data_out_ready(out_ready), .o__evict_valid(bp_ev_valid),
        .o__evict_priority(bp_ev_pri), .o__evict_data(bp_ev_data),
        .o__count(bp_count), .o__full(bp_full), .o__empty(bp_empty)
    );

    pifo_pushout #(.NUM_ELEMENTS(N), .PRIORITY_WIDTH(PW), .DATA_WIDTH(DW), .MODE_PUSHOUT(1)) u_po (
        .clk(clk), .reset(reset),
`ifdef PIFO_CLEAR_ALL_EN
        .i__clear_all(clear_all),
`endif
        .i__data_in_valid(in_valid), .i__data_in_priority(in_pri), .i__data_in(in_data),
        .o__data_in_ready(po_in_ready), .o__data_out_valid(po_out_valid),
        .o__data_out_priority(po_out_pri), .o__data_out(po_out_data),
        .i__data_out_ready(out_ready), .o__evict_valid(po_ev_valid),
        .o__evict_priority(po_ev_pri), .o__evict_data(po_ev_data),
        .o__count(po_count), .o__full(po_full), .o__empty(po_empty)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        clear_all = 1'b0;
        in_valid  = 1'b0;
        in_pri    = '0;
        in_data   = '0;
        out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic enq(input int p, input int d);
        in_valid = 1'b1;
        in_pri   = PW'(p);
        in_data  = DW'(d);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic fill_10_25();
        for (int i = 0; i < N; i++) enq(10 + i, 100 + i);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (bp_count !== 0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", bp_count); end
        n_checks++; if (bp_empty !== 1'b1 || bp_full !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got empty=%0b full=%0b expected 1/0", bp_empty, bp_full); end
        n_checks++; if (bp_in_ready !== 1'b1 || po_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b/%0b expected 1/1", bp_in_ready, po_in_ready); end
        n_checks++; if (po_out_valid !== 1'b0 || po_out_pri !== 0 || po_out_data !== 0) begin n_fail++; $display("FAIL reset_head: got v=%0b p=%0d d=%0d expected 0/0/0", po_out_valid, po_out_pri, po_out_data); end
        n_checks++; if (po_ev_valid !== 1'b0 || po_ev_pri !== 0 || po_ev_data !== 0) begin n_fail++; $display("FAIL reset_evict: got v=%0b p=%0d d=%0d expected 0/0/0", po_ev_valid, po_ev_pri, po_ev_data); end
    endtask

    task automatic test_order();
        int exp_p [4] = '{2, 2, 5, 9};
        int exp_d [4] = '{'hB, 'hD, 'hA, 'hC};
        do_reset();
        enq(5, 'hA); enq(2, 'hB); enq(9, 'hC); enq(2, 'hD);
        n_checks++; if (po_count !== 4) begin n_fail++; $display("FAIL order_count: got %0d expected 4", po_count); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (po_out_valid !== 1'b1 || po_out_pri !== PW'(exp_p[i]) || po_out_data !== DW'(exp_d[i])) begin
                n_fail++; $display("FAIL order_%0d: got v=%0b p=%0d d=%0h expected 1/%0d/%0h", i, po_out_valid, po_out_pri, po_out_data, exp_p[i], exp_d[i]);
            end
            n_checks++;
            if (bp_out_pri !== PW'(exp_p[i]) || bp_out_data !== DW'(exp_d[i])) begin
                n_fail++; $display("FAIL order_bp_%0d: got p=%0d d=%0h expected %0d/%0h", i, bp_out_pri, bp_out_data, exp_p[i], exp_d[i]);
            end
            tick();
        end
        out_ready = 1'b0;
        n_checks++; if (po_empty !== 1'b1 || po_count !== 0 || po_out_valid !== 1'b0) begin n_fail++; $display("FAIL order_drained: got empty=%0b count=%0d v=%0b expected 1/0/0", po_empty, po_count, po_out_valid); end
    endtask

    task automatic test_backpressure();
        do_reset();
        fill_10_25();
        n_checks++; if (bp_full !== 1'b1 || bp_in_ready !== 1'b0 || bp_count !== 16) begin n_fail++; $display("FAIL bp_full: got full=%0b ready=%0b count=%0d expected 1/0/16", bp_full, bp_in_ready, bp_count); end
        n_checks++; if (po_full !== 1'b1 || po_in_ready !== 1'b1) begin n_fail++; $display("FAIL po_full_ready: got full=%0b ready=%0b expected 1/1", po_full, po_in_ready); end
        enq(1, 'h11);
        n_checks++; if (bp_out_pri !== 10 || bp_count !== 16 || bp_ev_valid !== 1'b0) begin n_fail++; $display("FAIL bp_ignored: got head=%0d count=%0d ev=%0b expected 10/16/0", bp_out_pri, bp_count, bp_ev_valid); end
        n_checks++; if (po_ev_valid !== 1'b1 || po_ev_pri !== 25 || po_out_pri !== 1) begin n_fail++; $display("FAIL po_evict_on_1: got ev=%0b evp=%0d head=%0d expected 1/25/1", po_ev_valid, po_ev_pri, po_out_pri); end
        out_ready = 1'b1;
        n_checks++; if (bp_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_same_cycle: got %0b expected 0", bp_in_ready); end
        tick();
        out_ready = 1'b0;
        n_checks++; if (bp_in_ready !== 1'b1 || bp_count !== 15 || bp_out_pri !== 11) begin n_fail++; $display("FAIL bp_ready_after_deq: got ready=%0b count=%0d head=%0d expected 1/15/11", bp_in_ready, bp_count, bp_out_pri); end
    endtask

    task automatic test_pushout();
        do_reset();
        fill_10_25();
        enq(3, 'h33);
        n_checks++; if (po_ev_valid !== 1'b1 || po_ev_pri !== 25 || po_ev_data !== 115) begin n_fail++; $display("FAIL po_evict_tail: got v=%0b p=%0d d=%0d expected 1/25/115", po_ev_valid, po_ev_pri, po_ev_data); end
        n_checks++; if (po_out_pri !== 3 || po_out_data !== 'h33 || po_count !== 16) begin n_fail++; $display("FAIL po_head_3: got p=%0d d=%0h count=%0d expected 3/33/16", po_out_pri, po_out_data, po_count); end
        n_checks++; if (bp_out_pri !== 10 || bp_ev_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_evict: got head=%0d ev=%0b expected 10/0", bp_out_pri, bp_ev_valid); end
        tick();
        n_checks++; if (po_ev_valid !== 1'b0) begin n_fail++; $display("FAIL po_evict_pulse: got %0b expected 0", po_ev_valid); end
        enq(25, 'h77);
        n_checks++; if (po_ev_valid !== 1'b1 || po_ev_pri !== 25 || po_ev_data !== 'h77 || po_out_pri !== 3 || po_count !== 16) begin n_fail++; $display("FAIL po_evict_incoming: got v=%0b p=%0d d=%0h head=%0d count=%0d expected 1/25/77/3/16", po_ev_valid, po_ev_pri, po_ev_data, po_out_pri, po_count); end
        // Full + enqueue + dequeue: both happen, no eviction.
        out_ready = 1'b1;
        enq(5, 'h55);
        out_ready = 1'b0;
        n_checks++; if (po_ev_valid !== 1'b0 || po_count !== 16 || po_out_pri !== 5) begin n_fail++; $display("FAIL po_full_enq_deq: got ev=%0b count=%0d head=%0d expected 0/16/5", po_ev_valid, po_count, po_out_pri); end
        n_checks++; if (bp_count !== 15 || bp_out_pri !== 11) begin n_fail++; $display("FAIL bp_full_enq_deq: got count=%0d head=%0d expected 15/11", bp_count, bp_out_pri); end
        // Remaining order must be 5, 10..24.
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (po_out_pri !== PW'((i == 0) ? 5 : 9 + i)) begin
                n_fail++; $display("FAIL po_drain_%0d: got %0d expected %0d", i, po_out_pri, (i == 0) ? 5 : 9 + i);
            end
            tick();
        end
        out_ready = 1'b0;
        n_checks++; if (po_empty !== 1'b1) begin n_fail++; $display("FAIL po_drain_empty: got %0b expected 1", po_empty); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        enq(4, 'h4); enq(8, 'h8);
        out_ready = 1'b1;
        enq(6, 'h6);
        out_ready = 1'b0;
        n_checks++; if (po_out_pri !== 6 || po_out_data !== 'h6 || po_count !== 2) begin n_fail++; $display("FAIL b2b_head: got p=%0d d=%0h count=%0d expected 6/6/2", po_out_pri, po_out_data, po_count); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++; if (po_out_pri !== 8 || po_count !== 1) begin n_fail++; $display("FAIL b2b_next: got p=%0d count=%0d expected 8/1", po_out_pri, po_count); end
    endtask

    task automatic test_empty_enq_deq();
        do_reset();
        out_ready = 1'b1;
        enq(7, 'h7);
        out_ready = 1'b0;
        n_checks++; if (po_out_valid !== 1'b1 || po_out_pri !== 7 || po_count !== 1) begin n_fail++; $display("FAIL empty_enq_deq: got v=%0b p=%0d count=%0d expected 1/7/1", po_out_valid, po_out_pri, po_count); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int i = 0; i < 5; i++) enq(20 - i, i);
        n_checks++; if (po_count !== 5 || po_out_pri !== 16) begin n_fail++; $display("FAIL pre_reset: got count=%0d head=%0d expected 5/16", po_count, po_out_pri); end
        reset    = 1'b1;
        in_valid = 1'b1; in_pri = 2; in_data = 'h22;
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        n_checks++; if (po_count !== 0 || po_empty !== 1'b1 || po_ev_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset: got count=%0d empty=%0b ev=%0b expected 0/1/0", po_count, po_empty, po_ev_valid); end
        tick();
        n_checks++; if (po_count !== 0 || po_out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_discard: got count=%0d v=%0b expected 0/0", po_count, po_out_valid); end
    endtask

`ifdef PIFO_CLEAR_ALL_EN
    task automatic test_clear_all();
        do_reset();
        for (int i = 0; i < 5; i++) enq(20 - i, i);
        clear_all = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1; in_pri = 2; in_data = 'h22;
        tick();
        clear_all = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        n_checks++; if (po_count !== 0 || po_empty !== 1'b1 || po_ev_valid !== 1'b0 || po_out_pri !== 0) begin n_fail++; $display("FAIL clear_all: got count=%0d empty=%0b ev=%0b head=%0d expected 0/1/0/0", po_count, po_empty, po_ev_valid, po_out_pri); end
        tick();
        n_checks++; if (bp_count !== 0 || po_out_valid !== 1'b0) begin n_fail++; $display("FAIL clear_all_discard: got count=%0d v=%0b expected 0/0", bp_count, po_out_valid); end
    endtask
`endif

    initial begin
        test_reset();
        test_order();
        test_backpressure();
        test_pushout();
        test_back_to_back();
        test_empty_enq_deq();
        test_mid_reset();
`ifdef PIFO_CLEAR_ALL_EN
        test_clear_all();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pifo_pushout.md
Name: pifo_pushout

Overview:
Parametrised, self-contained sorted-array PIFO for the packet scheduler. It is the successor to the fixed-configuration PIFO wrapper.
- Depth, priority width and payload width are generic.
- Adds a push-out mode: on full, the worst-ranked entry is evicted and reported instead of back-pressuring.
- Adds an occupancy count.
- Sits between the enqueue classifier and the egress dequeue arbiter; the eviction port feeds the drop/buffer-free logic.

Parameters:
NUM_ELEMENTS, 16, queue depth (>=2)
PRIORITY_WIDTH, 8, rank width; lower value = dequeued first
DATA_WIDTH, 16, payload (packet pointer) width
MODE_PUSHOUT, 1, 1 = evict on full; 0 = back-pressure on full

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
i__data_in_valid  in  1  enqueue request
i__data_in_priority  in  PRIORITY_WIDTH  enqueue rank
i__data_in  in  DATA_WIDTH  enqueue payload
o__data_in_ready  out  1  enqueue accepted when high
o__data_out_valid  out  1  head entry valid
o__data_out_priority  out  PRIORITY_WIDTH  head rank
o__data_out  out  DATA_WIDTH  head payload
i__data_out_ready  in  1  dequeue request
o__evict_valid  out  1  one-cycle eviction pulse
o__evict_priority  out  PRIORITY_WIDTH  evicted rank
o__evict_data  out  DATA_WIDTH  evicted payload
o__count  out  $clog2(NUM_ELEMENTS+1)  occupancy
o__full  out  1  count == NUM_ELEMENTS
o__empty  out  1  count == 0

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high on reset. All inputs are ignored while reset is high.
- Reset values:
  - count = 0; all slot valids = 0; slot contents = 0.
  - o__data_out_valid = 0; o__data_out_priority/o__data_out = 0.
  - o__evict_valid/o__evict_priority/o__evict_data = 0.
  - o__empty = 1; o__full = 0; o__data_in_ready = 1.
- Storage: slots 0..N-1, valid entries contiguous from slot 0, sorted by ascending priority; slot 0 is the head.
- Ties: equal priorities dequeue in arrival order. A new entry is inserted after all entries with priority <= its own.
- Head outputs are driven from registered slot 0 only; there is no combinational path from any input to head outputs. o__data_out_valid = ~o__empty.
- Dequeue fires when i__data_out_ready && o__data_out_valid. Entries shift toward the head on the next edge.
- Enqueue latency: an accepted entry is visible (in order) one cycle later. There is no same-cycle bypass.
  - Empty with enqueue + i__data_out_ready: no dequeue; the entry appears next cycle.
- MODE_PUSHOUT=0:
  - o__data_in_ready = ~o__full, from registered state.
  - A dequeue in the same cycle as full does not make ready high that cycle.
  - Enqueue while not ready is ignored and not reported.
- MODE_PUSHOUT=1: o__data_in_ready is constantly 1 outside reset. On enqueue while full without a same-cycle dequeue:
  - If incoming priority < tail priority: tail is evicted and the incoming entry is inserted. Count stays N.
  - If incoming priority >= tail priority: the incoming entry itself is evicted and the array is unchanged.
  - The evict outputs are registered and pulse for exactly one cycle, the cycle after the event.
- Full + enqueue + dequeue in the same cycle: both occur, no eviction, count stays N. This applies in both modes only when the enqueue is accepted.
- Simultaneous enqueue + dequeue when non-empty:
  - The insertion position is computed against the post-dequeue array.
  - Count is unchanged.
- Count: +1 on enqueue only, -1 on dequeue only, otherwise held. It never exceeds N and never underflows.
- Reset mid-operation: all contents are discarded next cycle with no eviction reported.

Optional Feature:
Macro PIFO_CLEAR_ALL_EN.
- Defined: adds port i__clear_all (in, 1).
  - When high, the next edge invalidates all slots, sets count to 0 and drives head outputs to 0.
  - Clear has priority over enqueue/dequeue in the same cycle, which are ignored.
  - No eviction is reported. Lower priority than reset.
- Undefined: port absent; no clear path is synthesised.

Test Plan:
1. Reset, enqueue (pri,data) (5,A),(2,B),(9,C),(2,D) on consecutive cycles, then hold i__data_out_ready=1 -> dequeue order B,D,A,C (2,2,5,9); o__empty=1 and count=0 afterwards.
2. MODE_PUSHOUT=0, N=16, fill with priorities 10..25 -> o__full=1, o__data_in_ready=0, count=16; an extra enqueue of pri 1 is ignored (head stays 10). Dequeue once -> ready=1 the next cycle.
3. MODE_PUSHOUT=1, full with 10..25, enqueue pri 3 -> next cycle evict_valid=1, evict_priority=25, head=3, count=16. Then enqueue pri 25 -> evict pulse reports incoming 25; array unchanged.
4. Array {4,8}, enqueue 6 with a same-cycle dequeue -> next cycle head=6, count=2; next dequeue gives 8.
5. Empty, enqueue 7 with i__data_out_ready=1 -> no dequeue that cycle; next cycle o__data_out_valid=1, priority=7, count=1.
6. With 5 entries, assert reset one cycle (and, with PIFO_CLEAR_ALL_EN, i__clear_all in a separate run together with an enqueue) -> next cycle count=0, o__empty=1, evict_valid=0, the enqueue is discarded.
